morse_encoder: RTL and testbench
================================

Name: morse_encoder

Overview:
Converts a stream of ASCII characters into timed Morse keying for the TX side of the Morse path. Accepts one character per valid/ready handshake and emits an on/off key waveform with standard unit timing. It also emits a 2-bit element strobe using the same dot/dash code as the Morse decoder input, so the two blocks can be looped back. Sits between the character source (host/UART side) and the key/LED driver.

Parameters:
UNIT_CYCLES, 4, clock cycles per Morse time unit; legal range 1..65535
CNT_W, 16, width of the unit cycle counter; must hold UNIT_CYCLES-1

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
char_in  in  8  ASCII character to send
char_valid  in  1  char_in is valid
char_ready  out  1  encoder can accept a character
key_out  out  1  Morse key, 1 = tone/mark, 0 = silence
morse_signal  out  2  element strobe: 2'b01 dot, 2'b10 dash, 2'b00 otherwise; one clock wide at the first cycle of each mark
busy  out  1  character in progress, i.e. not IDLE
char_err  out  1  one-cycle pulse when an unsupported character is accepted

Behaviour:
- Reset (async, immediate): state IDLE, key_out=0, morse_signal=2'b00, char_err=0, busy=0, char_ready=1, all counters 0. Reset mid-character abandons the character and drops the key the same instant.
- Handshake: char_ready=1 only in IDLE. Transfer happens when char_valid && char_ready at a rising edge. char_in is captured at transfer and ignored afterwards. No buffering.
- Character table (combinational ROM): output is length len (0..4) and pattern bits (1 = dash), sent MSB-first.
  - 'A'-'Z' (0x41-0x5A): standard ITU codes.
  - 'a'-'z': folded to uppercase.
  - 0x20 (space): word gap.
  - Anything else: invalid.
- States: IDLE, MARK, ELEM_GAP, CHAR_GAP, WORD_GAP.
- Transfer of a valid letter: next state MARK with element index 0. key_out=1 from the cycle after transfer (latency 1). morse_signal carries the element code in that same first cycle.
- MARK: hold for 1 unit (dot) or 3 units (dash).
  - Not the last element: go to ELEM_GAP for 1 unit, key_out=0.
  - Last element: go to CHAR_GAP for 3 units, key_out=0.
- ELEM_GAP done: advance element index, go to MARK.
- CHAR_GAP or WORD_GAP done: go to IDLE. char_ready=1 in that next cycle.
- Space: go to WORD_GAP for 4 units, key_out=0. Together with the preceding 3-unit char gap this gives the 7-unit word gap.
- Invalid character: handshake completes and char_err pulses the cycle after transfer. No key activity. State stays IDLE, so char_ready=1 throughout.
- Unit timing: cycle counter runs 0..UNIT_CYCLES-1, and a unit counter runs 0..N-1 within the state. Both clear on every state entry. A state lasting N units occupies exactly N*UNIT_CYCLES clocks.
- Total clocks per letter: UNIT_CYCLES*(sum of mark units + (len-1) + 3).
- busy = (state != IDLE).
- char_valid may be held high continuously. Back-to-back characters then have no extra idle cycle beyond the single IDLE cycle.

Optional Feature:
MORSE_DIGITS_EN
- Defined: the ROM extends to 5-element codes. Pattern width becomes 5 and len becomes 0..5. '0'-'9' (0x30-0x39) map to the standard codes, e.g. '1' = .----, '0' = -----.
- Undefined: pattern width is 4, and digits are treated as invalid (char_err pulses).

Decomposition:
- Package morse_pkg:
  - MORSE_DOT=2'b01, MORSE_DASH=2'b10, MORSE_NONE=2'b00
  - unit-count constants DOT_UNITS=1, DASH_UNITS=3, ELEM_GAP_UNITS=1, CHAR_GAP_UNITS=3, WORD_EXTRA_UNITS=4
  - state enum typedef
  - MAX_ELEMS (4, or 5 with MORSE_DIGITS_EN)
- Sub-module morse_char_rom: purely combinational. char_in -> {valid, is_space, len, pattern}.
- The FSM and counters stay in morse_encoder.

Test Plan:
- UNIT_CYCLES=2, send 'E' at cycle 0 -> key_out=1 cycles 1-2, morse_signal=01 at cycle 1 only, key_out=0 cycles 3-8, char_ready=1 at cycle 9.
- UNIT_CYCLES=2, send 'a' -> same waveform as 'A': key 1 for 2 clocks, 0 for 2, 1 for 6, 0 for 6. Strobes 01 then 10. busy high for 16 clocks.
- Stream "SOS" with char_valid held high -> 3 dots, 3 dashes, 3 dots. Exactly 9 morse_signal strobes. Inter-letter silence 3 units (+1 IDLE cycle).
- Send '#' -> char_err one-cycle pulse, key_out stays 0, char_ready never drops.
- Send "A A" -> key-off between the two 'A's totals 3+4 units (+IDLE cycles).
- Assert rst_n=0 mid-dash of 'T' -> key_out=0 asynchronously. After release: IDLE, char_ready=1, no residual strobe. With MORSE_DIGITS_EN, '5' -> five dot strobes.

Source files
------------

// File: rtl/morse_pkg.sv
// ============================================================================
// morse_pkg : shared constants, state encoding and ROM record for the Morse TX
// Optional build macro: MORSE_DIGITS_EN (adds 5-element digit codes)
// Revision: 1.0
// ============================================================================
`default_nettype none

package morse_pkg;

    localparam logic [1:0] MORSE_NONE = 2'b00;
    localparam logic [1:0] MORSE_DOT  = 2'b01;
    localparam logic [1:0] MORSE_DASH = 2'b10;

    localparam logic [2:0] DOT_UNITS        = 3'd1;
    localparam logic [2:0] DASH_UNITS       = 3'd3;
    localparam logic [2:0] ELEM_GAP_UNITS   = 3'd1;
    localparam logic [2:0] CHAR_GAP_UNITS   = 3'd3;
    localparam logic [2:0] WORD_EXTRA_UNITS = 3'd4;

`ifdef MORSE_DIGITS_EN
    localparam int MAX_ELEMS = 5;
`else
    localparam int MAX_ELEMS = 4;
`endif

    localparam int PAT_W = MAX_ELEMS;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_MARK     = 3'd1,
        ST_ELEM_GAP = 3'd2,
        ST_CHAR_GAP = 3'd3,
        ST_WORD_GAP = 3'd4
    } state_t;

    // pattern is left-aligned: element 0 sits in the MSB, 1 = dash
    typedef struct packed {
        logic             valid;
        logic             is_space;
        logic [2:0]       len;
        logic [PAT_W-1:0] pattern;
    } rom_out_t;

endpackage

`default_nettype wire

// File: rtl/morse_encoder_if.sv
// ============================================================================
// morse_encoder_if : character valid/ready handshake into the Morse encoder
// Revision: 1.0
// ============================================================================
`default_nettype none

interface morse_encoder_if;
    logic [7:0] char_in;
    logic       char_valid;
    logic       char_ready;

    modport master (output char_in, output char_valid, input  char_ready);
    modport slave  (input  char_in, input  char_valid, output char_ready);
endinterface

`default_nettype wire

// File: rtl/morse_char_rom.sv
// ============================================================================
// morse_char_rom : combinational ASCII -> Morse code table (case-folded)
// Optional build macro: MORSE_DIGITS_EN (adds '0'-'9')
// Revision: 1.0
// ============================================================================
`default_nettype none

module morse_char_rom
    import morse_pkg::*;
(
    input  logic [7:0] char_in,
    output rom_out_t   rom_out
);

    logic [7:0] upper;
    logic [7:0] code;      // {len[2:0], right-aligned bits[4:0]}
    logic [4:0] aligned;

    always_comb begin
        upper = char_in;
        if (char_in >= "a" && char_in <= "z")
            upper = char_in - 8'h20;

        code = 8'h00;
        case (upper)
            "A": code = {3'd2, 5'b00001};
            "B": code = {3'd4, 5'b01000};
            "C": code = {3'd4, 5'b01010};
            "D": code = {3'd3, 5'b00100};
            "E": code = {3'd1, 5'b00000};
            "F": code = {3'd4, 5'b00010};
            "G": code = {3'd3, 5'b00110};
            "H": code = {3'd4, 5'b00000};
            "I": code = {3'd2, 5'b00000};
            "J": code = {3'd4, 5'b00111};
            "K": code = {3'd3, 5'b00101};
            "L": code = {3'd4, 5'b00100};
            "M": code = {3'd2, 5'b00011};
            "N": code = {3'd2, 5'b00010};
            "O": code = {3'd3, 5'b00111};
            "P": code = {3'd4, 5'b00110};
            "Q": code = {3'd4, 5'b01101};
            "R": code = {3'd3, 5'b00010};
            "S": code = {3'd3, 5'b00000};
            "T": code = {3'd1, 5'b00001};
            "U": code = {3'd3, 5'b00001};
            "V": code = {3'd4, 5'b00001};
            "W": code = {3'd3, 5'b00011};
            "X": code = {3'd4, 5'b01001};
            "Y": code = {3'd4, 5'b01011};
            "Z": code = {3'd4, 5'b01100};
`ifdef MORSE_DIGITS_EN
            "0": code = {3'd5, 5'b11111};
            "1": code = {3'd5, 5'b01111};
            "2": code = {3'd5, 5'b00111};
            "3": code = {3'd5, 5'b00011};
            "4": code = {3'd5, 5'b00001};
            "5": code = {3'd5, 5'b00000};
            "6": code = {3'd5, 5'b10000};
            "7": code = {3'd5, 5'b11000};
            "8": code = {3'd5, 5'b11100};
            "9": code = {3'd5, 5'b11110};
`endif
            default: code = 8'h00;
        endcase

        // left-align so the first element to send lands in the MSB
        aligned = code[4:0] << (3'd5 - code[7:5]);

        rom_out.is_space = (upper == 8'h20);
        rom_out.valid    = (code[7:5] != 3'd0) || rom_out.is_space;
        rom_out.len      = code[7:5];
        rom_out.pattern  = aligned[4 -: PAT_W];
    end

endmodule

`default_nettype wire

// File: rtl/morse_encoder.sv
// ============================================================================
// morse_encoder : ASCII character stream -> timed Morse key and element strobes
// Optional build macro: MORSE_DIGITS_EN (digits '0'-'9' become encodable)
// Revision: 1.0
// ============================================================================
`default_nettype none

module morse_encoder
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES = 4,
    parameter int CNT_W       = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    morse_encoder_if.slave  ch,
    output logic            key_out,
    output logic [1:0]      morse_signal,
    output logic            busy,
    output logic            char_err
);

    localparam logic [CNT_W-1:0] UNIT_LAST = CNT_W'(UNIT_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cycle_cnt;
    logic [2:0]       unit_cnt;
    logic [2:0]       elem_idx;
    logic [2:0]       len;
    logic [PAT_W-1:0] pattern;   // shifted left as elements are consumed

    rom_out_t         rom;
    logic [2:0]       state_units;
    logic             unit_end;
    logic             state_done;
    logic             last_elem;
    logic             accept;

    morse_char_rom u_rom (
        .char_in (ch.char_in),
        .rom_out (rom)
    );

    always_comb begin
        state_units = DOT_UNITS;
        case (state)
            ST_MARK:     state_units = pattern[PAT_W-1] ? DASH_UNITS : DOT_UNITS;
            ST_ELEM_GAP: state_units = ELEM_GAP_UNITS;
            ST_CHAR_GAP: state_units = CHAR_GAP_UNITS;
            ST_WORD_GAP: state_units = WORD_EXTRA_UNITS;
            default:     state_units = DOT_UNITS;
        endcase
    end

    assign unit_end   = (cycle_cnt == UNIT_LAST);
    assign state_done = unit_end && (unit_cnt == state_units - 3'd1);
    assign last_elem  = (elem_idx == len - 3'd1);
    assign accept     = ch.char_valid && (state == ST_IDLE);

    assign ch.char_ready = (state == ST_IDLE);
    assign busy          = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            cycle_cnt    <= '0;
            unit_cnt     <= '0;
            elem_idx     <= '0;
            len          <= '0;
            pattern      <= '0;
            key_out      <= 1'b0;
            morse_signal <= MORSE_NONE;
            char_err     <= 1'b0;
        end else begin
            morse_signal <= MORSE_NONE;
            char_err     <= 1'b0;

            // counters clear on every state change, so each state starts at 0/0
            if (state != ST_IDLE) begin
                if (state_done) begin
                    cycle_cnt <= '0;
                    unit_cnt  <= '0;
                end else if (unit_end) begin
                    cycle_cnt <= '0;
                    unit_cnt  <= unit_cnt + 3'd1;
                end else begin
                    cycle_cnt <= cycle_cnt + 1'b1;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (rom.is_space) begin
                            state <= ST_WORD_GAP;
                        end else if (rom.valid) begin
                            state        <= ST_MARK;
                            key_out      <= 1'b1;
                            morse_signal <= rom.pattern[PAT_W-1] ? MORSE_DASH : MORSE_DOT;
                            pattern      <= rom.pattern;
                            len          <= rom.len;
                            elem_idx     <= '0;
                        end else begin
                            char_err <= 1'b1;
                        end
                    end
                end
                ST_MARK: begin
                    if (state_done) begin
                        key_out <= 1'b0;
                        state   <= last_elem ? ST_CHAR_GAP : ST_ELEM_GAP;
                    end
                end
                ST_ELEM_GAP: begin
                    if (state_done) begin
                        state        <= ST_MARK;
                        key_out      <= 1'b1;
                        morse_signal <= pattern[PAT_W-2] ? MORSE_DASH : MORSE_DOT;
                        pattern      <= pattern << 1;
                        elem_idx     <= elem_idx + 3'd1;
                    end
                end
                ST_CHAR_GAP, ST_WORD_GAP: begin
                    if (state_done)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_morse_encoder.sv
// ============================================================================
// tb_morse_encoder : streams characters and compares the key waveform against
// a per-cycle trace built from Morse dot/dash strings.  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_morse_encoder;

    localparam int U = 2;

    logic       clk;
    logic       rst_n;
    logic       key_out;
    logic [1:0] morse_signal;
    logic       busy;
    logic       char_err;

    morse_encoder_if ch ();

    morse_encoder #(.UNIT_CYCLES(U), .CNT_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ch           (ch.slave),
        .key_out      (key_out),
        .morse_signal (morse_signal),
        .busy         (busy),
        .char_err     (char_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    typedef struct packed {
        logic       key;
        logic [1:0] sig;
        logic       busy;
        logic       err;
        logic       idle;
    } exp_t;

    exp_t exp_q[$];

    string letters[26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....",
                           "..", ".---", "-.-", ".-..", "--", "-.", "---", ".--.",
                           "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-",
                           "-.--", "--.."};
    string digits[10]  = '{"-----", ".----", "..---", "...--", "....-",
                           ".....", "-....", "--...", "---..", "----."};

    function automatic exp_t mk(input logic k, input logic [1:0] s, input logic b,
                                input logic e, input logic i);
        exp_t x;
        x.key = k; x.sig = s; x.busy = b; x.err = e; x.idle = i;
        return x;
    endfunction

    // Expected cycles from the cycle after a character's transfer up to and
    // including the idle cycle in which the following transfer can happen.
    task automatic append_char(input logic [7:0] c);
        logic [7:0] u;
        string      code;
        int         n;
        u    = c;
        code = "";
        if (u >= "a" && u <= "z") u = u - 8'd32;
        if (u >= "A" && u <= "Z") code = letters[u - "A"];
`ifdef MORSE_DIGITS_EN
        if (u >= "0" && u <= "9") code = digits[u - "0"];
`endif
        if (u == " ") begin
            for (int i = 0; i < 4 * U; i++) exp_q.push_back(mk(0, 2'b00, 1, 0, 0));
            exp_q.push_back(mk(0, 2'b00, 0, 0, 1));
        end else if (code.len() == 0) begin
            exp_q.push_back(mk(0, 2'b00, 0, 1, 1));
        end else begin
            for (int e = 0; e < code.len(); e++) begin
                n = (code[e] == "-") ? 3 * U : U;
                for (int i = 0; i < n; i++)
                    exp_q.push_back(mk(1, (i != 0) ? 2'b00 : (code[e] == "-") ? 2'b10 : 2'b01, 1, 0, 0));
                n = (e == code.len() - 1) ? 3 * U : U;
                for (int i = 0; i < n; i++) exp_q.push_back(mk(0, 2'b00, 1, 0, 0));
            end
            exp_q.push_back(mk(0, 2'b00, 0, 0, 1));
        end
    endtask

    // Entered #1 after a rising edge with the encoder idle; leaves it the same way.
    task automatic run_seq(input logic [7:0] s[$]);
        int   nxt;
        exp_t e;
        exp_q.delete();
        foreach (s[i]) append_char(s[i]);
        ch.char_in    = s[0];
        ch.char_valid = 1'b1;
        nxt = 1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            @(posedge clk);
            #1;
            check("key_out",      key_out,       e.key);
            check("morse_signal", morse_signal,  e.sig);
            check("busy",         busy,          e.busy);
            check("char_err",     char_err,      e.err);
            check("char_ready",   ch.char_ready, e.idle);
            if (e.idle) begin
                if (nxt < s.size()) begin
                    ch.char_in = s[nxt];
                    nxt++;
                end else begin
                    ch.char_valid = 1'b0;
                end
            end
        end
    endtask

    task automatic run_str(input string str);
        logic [7:0] q[$];
        for (int i = 0; i < str.len(); i++) q.push_back(str[i]);
        run_seq(q);
    endtask

    initial begin
        string      punct;
        logic [7:0] rq[$];
        int         kind;

        punct         = "#!?.,/";
        rst_n         = 1'b0;
        ch.char_in    = 8'h00;
        ch.char_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst key_out",      key_out,       0);
        check("rst morse_signal", morse_signal,  0);
        check("rst busy",         busy,          0);
        check("rst char_err",     char_err,      0);
        check("rst char_ready",   ch.char_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_str("E");
        run_str("a");
        run_str("SOS");
        run_str("#");
        run_str("A A");
        run_str("5E0z");

        for (int r = 0; r < 6; r++) begin
            rq.delete();
            for (int k = 0; k < $urandom_range(3, 8); k++) begin
                kind = $urandom_range(0, 9);
                if (kind <= 4)      rq.push_back(8'($urandom_range(65, 90)));
                else if (kind <= 6) rq.push_back(8'($urandom_range(97, 122)));
                else if (kind == 7) rq.push_back(8'h20);
                else if (kind == 8) rq.push_back(8'($urandom_range(48, 57)));
                else                rq.push_back(punct[$urandom_range(0, 5)]);
            end
            run_seq(rq);
        end

        // reset in the middle of the dash of 'T'
        ch.char_in    = "T";
        ch.char_valid = 1'b1;
        @(posedge clk);
        #1;
        ch.char_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("T mid-dash key_out", key_out, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst key_out",      key_out,       0);
        check("async rst morse_signal", morse_signal,  0);
        check("async rst busy",         busy,          0);
        check("async rst char_ready",   ch.char_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("post rst key_out",      key_out,       0);
            check("post rst morse_signal", morse_signal,  0);
            check("post rst char_ready",   ch.char_ready, 1);
        end

        run_str("T");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
